// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the fetch stage, the fetch queue and decode.
//   master: driven by fetch/decode (start_i, flush_i, valid_i, pc_i, instr_i, ready_i).
//   slave : the fetch queue (ready_o, valid_o, pc_o, instr_o, count_o).
// Signal names keep the queue-relative _i/_o suffixes so both sides agree on meaning.
interface fetch_queue_if #(
  parameter int unsigned PTR_W = 2
);
  logic             start_i;
  logic             flush_i;
  logic             valid_i;
  logic [31:0]      pc_i;
  logic [31:0]      instr_i;
  logic             ready_o;
  logic             valid_o;
  logic [31:0]      pc_o;
  logic [31:0]      instr_o;
  logic             ready_i;
  logic [PTR_W:0]   count_o;

  modport master (
    output start_i, flush_i, valid_i, pc_i, instr_i, ready_i,
    input  ready_o, valid_o, pc_o, instr_o, count_o
  );

  modport slave (
    input  start_i, flush_i, valid_i, pc_i, instr_i, ready_i,
    output ready_o, valid_o, pc_o, instr_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of {pc, instruction} pairs between instruction fetch and IF/ID decode.
// Ports:
//   clk_i - clock, state updates on rising edge
//   rst_i - asynchronous active-high reset
//   bus   - fetch_queue_if.slave: push side (start_i, flush_i, valid_i, pc_i, instr_i, ready_o),
//           pop side (valid_o, pc_o, instr_o, ready_i) and occupancy count_o.
// ready_o doubles as the PC write enable. flush_i drops every buffered (wrong-path) entry.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming entry to the
// outputs in the same cycle; without it the minimum latency is one cycle.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_W     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk_i,
  input logic          rst_i,
  fetch_queue_if.slave bus
);

  localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic empty, full, push, pop, wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == Full);

  // Ready looks only at the registered count: a full queue refuses even with a same-cycle pop.
  assign bus.ready_o = ~full;
  assign push        = bus.valid_i & ~full & bus.start_i & ~bus.flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = empty & push;
  assign bus.valid_o = ~empty | bypass;
  assign pop         = bus.valid_o & bus.ready_i & ~bus.flush_i;
  // A bypassed entry taken by decode this cycle never touches storage.
  assign wr_en       = push & ~(bypass & bus.ready_i);
  assign rd_en       = pop & ~empty;

  always_comb begin
    bus.pc_o    = 32'h0;
    bus.instr_o = NOP_INSTR;
    if (!empty) begin
      bus.pc_o    = pc_mem[rd_ptr_q];
      bus.instr_o = instr_mem[rd_ptr_q];
    end else if (bypass) begin
      bus.pc_o    = bus.pc_i;
      bus.instr_o = bus.instr_i;
    end
  end
`else
  assign bus.valid_o = ~empty;
  assign pop         = bus.valid_o & bus.ready_i & ~bus.flush_i;
  assign wr_en       = push;
  assign rd_en       = pop;

  always_comb begin
    bus.pc_o    = 32'h0;
    bus.instr_o = NOP_INSTR;
    if (!empty) begin
      bus.pc_o    = pc_mem[rd_ptr_q];
      bus.instr_o = instr_mem[rd_ptr_q];
    end
  end
`endif

  assign bus.count_o = count_q;

  // Storage is not reset; count_q gates every read of it.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= bus.pc_i;
      instr_mem[wr_ptr_q] <= bus.instr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed, table-driven bench for fetch_queue (DEPTH=4) plus hand-written
// sequences for pointer wrap, asynchronous reset and first-entry latency.
module tb_fetch_queue;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_queue_if #(.PTR_W(2)) bus ();

  fetch_queue #(
    .DEPTH    (4),
    .PTR_W    (2),
    .NOP_INSTR(Nop)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        start;
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic        ready;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    int          exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hABCD_0000;
  endfunction

  function automatic void add(input logic s, input logic f, input logic v, input logic [31:0] pc,
                              input logic r, input logic er, input logic ev,
                              input logic [31:0] epc, input int ec);
    vec_t t;
    t = '{start: s, flush: f, valid: v, pc: pc, ready: r, exp_ready: er, exp_valid: ev,
          exp_pc: epc, exp_count: ec};
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks all outputs against an expected queue state; instruction follows from pc.
  task automatic check_state(input string tag, input logic er, input logic ev,
                             input logic [31:0] epc, input int ec);
    check({tag, ".ready_o"}, 32'(bus.ready_o), 32'(er));
    check({tag, ".valid_o"}, 32'(bus.valid_o), 32'(ev));
    check({tag, ".pc_o"},    bus.pc_o, epc);
    check({tag, ".instr_o"}, bus.instr_o, ev ? instr_of(epc) : Nop);
    check({tag, ".count_o"}, 32'(bus.count_o), 32'(ec));
  endtask

  task automatic drive(input logic s, input logic f, input logic v, input logic [31:0] pc,
                       input logic r);
    bus.start_i = s;
    bus.flush_i = f;
    bus.valid_i = v;
    bus.pc_i    = pc;
    bus.instr_i = instr_of(pc);
    bus.ready_i = r;
  endtask

  initial begin
    logic push_ok, pop_ok;
    int   pushed, got;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check_state("reset", 1'b1, 1'b0, 32'h0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_state("idle", 1'b1, 1'b0, 32'h0, 0);

    // start flush valid pc ready | ready_o valid_o pc_o count_o (after the edge)
    // Streaming with decode ready: one entry in flight at a time.
    add(1, 0, 1, 32'h00, 1,  1, 1, 32'h00, 1);
    add(1, 0, 1, 32'h04, 1,  1, 1, 32'h04, 1);
    add(1, 0, 1, 32'h08, 1,  1, 1, 32'h08, 1);
    add(1, 0, 0, 32'h00, 1,  1, 0, 32'h00, 0);
    // Fill while decode stalls; 0x10 and 0x14 are refused by the full queue.
    add(1, 0, 1, 32'h00, 0,  1, 1, 32'h00, 1);
    add(1, 0, 1, 32'h04, 0,  1, 1, 32'h00, 2);
    add(1, 0, 1, 32'h08, 0,  1, 1, 32'h00, 3);
    add(1, 0, 1, 32'h0C, 0,  0, 1, 32'h00, 4);
    add(1, 0, 1, 32'h10, 0,  0, 1, 32'h00, 4);
    add(1, 0, 1, 32'h14, 1,  1, 1, 32'h04, 3);
    add(1, 0, 0, 32'h00, 1,  1, 1, 32'h08, 2);
    add(1, 0, 0, 32'h00, 1,  1, 1, 32'h0C, 1);
    add(1, 0, 0, 32'h00, 1,  1, 0, 32'h00, 0);
    // Three entries, then push + pop + flush together: everything discarded.
    add(1, 0, 1, 32'h100, 0, 1, 1, 32'h100, 1);
    add(1, 0, 1, 32'h104, 0, 1, 1, 32'h100, 2);
    add(1, 0, 1, 32'h108, 0, 1, 1, 32'h100, 3);
    add(1, 1, 1, 32'h20, 1,  1, 0, 32'h00, 0);
    add(1, 0, 0, 32'h00, 1,  1, 0, 32'h00, 0);
    // start_i low blocks pushes but not pops; flush on an empty queue.
    add(0, 0, 1, 32'h30, 0,  1, 0, 32'h00, 0);
    add(1, 0, 1, 32'h30, 0,  1, 1, 32'h30, 1);
    add(0, 0, 1, 32'h34, 1,  1, 0, 32'h00, 0);
    add(1, 1, 0, 32'h00, 0,  1, 0, 32'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].flush, vecs[i].valid, vecs[i].pc, vecs[i].ready);
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                  vecs[i].exp_pc, vecs[i].exp_count);
    end

    // Wrap-around: ten pushes with interleaved pops must come out in order exactly once.
    pushed = 0;
    got    = 0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      drive(1'b1, 1'b0, pushed < 10, 32'(pushed * 4), (cyc % 3) != 0);
      #1;
      push_ok = bus.valid_i && bus.ready_o;
      pop_ok  = bus.valid_o && bus.ready_i;
      if (pop_ok) begin
        check($sformatf("wrap_pc%0d", got), bus.pc_o, 32'(got * 4));
        check($sformatf("wrap_instr%0d", got), bus.instr_o, instr_of(32'(got * 4)));
        got++;
      end
      if (push_ok) pushed++;
      @(posedge clk);
      #1;
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("wrap_popped", 32'(got), 32'd10);
    check("wrap_count", 32'(bus.count_o), 32'd0);

    // Asynchronous reset between edges while holding two entries.
    drive(1'b1, 1'b0, 1'b1, 32'h50, 1'b0);
    @(posedge clk);
    #1;
    bus.pc_i = 32'h54;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    #1;
    check_state("pre_rst", 1'b1, 1'b1, 32'h50, 2);
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 1'b1, 1'b0, 32'h0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_state("post_rst", 1'b1, 1'b0, 32'h0, 0);

    // First-entry latency from an empty queue with decode ready.
    drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check_state("lat_same", 1'b1, 1'b1, 32'h40, 0);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    #1;
    check_state("lat_next", 1'b1, 1'b0, 32'h0, 0);
`else
    check_state("lat_same", 1'b1, 1'b0, 32'h0, 0);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    #1;
    check_state("lat_next", 1'b1, 1'b1, 32'h40, 1);
    @(posedge clk);
    #1;
    check_state("lat_drain", 1'b1, 1'b0, 32'h0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the PC register/instruction memory and the IF/ID decode stage.
- Buffers {pc, instruction} pairs in a small FIFO so decode stalls do not lose fetched instructions.
- Drives the PC write-enable through ready_o.
- Discards all wrong-path entries on a branch/jump flush.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).
- NOP_INSTR, 32'h00000013, instruction presented on instr_o when the queue is empty (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  fetch enable; when low, no push is accepted.
- flush_i  in  1  branch/jump taken in a later stage; clear queue.
- valid_i  in  1  pc_i/instr_i hold a fetched instruction this cycle.
- pc_i  in  32  address of the fetched instruction.
- instr_i  in  32  fetched instruction word.
- ready_o  out  1  queue can accept a push; wired to the PC write enable.
- valid_o  out  1  head entry present for decode.
- pc_o  out  32  head entry PC.
- instr_o  out  32  head entry instruction.
- ready_i  in  1  decode accepts the head this cycle (inverse of ID stall).
- count_o  out  PTR_W+1  number of occupied entries (0..DEPTH).

Behaviour:
- Reset (async, rst_i=1): wr_ptr=0, rd_ptr=0, count=0. Outputs while in reset: valid_o=0, ready_o=1, pc_o=0, instr_o=NOP_INSTR, count_o=0. Storage contents are don't-care.
- push = valid_i & ready_o & start_i & ~flush_i.
- pop = valid_o & ready_i & ~flush_i.
- ready_o = (count != DEPTH). Combinational from registered count only; it does not look ahead to a same-cycle pop. When full, ready_o=0 even if a pop occurs in that cycle.
- valid_o = (count != 0). When valid_o=1: pc_o/instr_o = storage[rd_ptr]. When valid_o=0: pc_o=0, instr_o=NOP_INSTR.
- Push: storage[wr_ptr] <= {pc_i, instr_i}; wr_ptr increments modulo DEPTH (natural wrap of PTR_W bits).
- Pop: rd_ptr increments modulo DEPTH.
- count update: push only +1; pop only -1; push & pop 0, with both pointers advancing; neither 0.
- Latency, without the optional feature: an entry pushed in cycle N is visible on valid_o/pc_o/instr_o in cycle N+1. Entries are FIFO order; no reordering or duplication.
- Flush (flush_i=1 at a clock edge): highest priority. wr_ptr=rd_ptr=0, count=0. Any same-cycle push and pop are discarded. In the next cycle valid_o=0 and ready_o=1.
- Flush when already empty: no effect beyond resetting the pointers.
- Full boundary: count=DEPTH gives ready_o=0, so valid_i is ignored and the PC holds.
- Empty boundary: count=0 gives valid_o=0, so ready_i is ignored and decode sees a NOP bubble.
- start_i=0 blocks pushes only; pops and flush still operate.
- Reset asserted mid-operation: immediate return to the reset state, independent of clk_i. All buffered entries are lost.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count=0 and push would occur, {pc_i, instr_i} drive pc_o/instr_o combinationally and valid_o=1 in the same cycle.
  - If ready_i=1 in that cycle, the entry is consumed directly. It is not written to storage and count stays 0.
  - If ready_i=0, it is written normally and count becomes 1.
  - flush_i=1 suppresses the bypass: valid_o=0 that cycle.
- Not defined: no combinational path from valid_i/pc_i/instr_i to the outputs. Minimum latency is one cycle, as above.

Test Plan:
- Reset, then idle -> valid_o=0, ready_o=1, instr_o=32'h00000013, count_o=0. Assert rst_i between clock edges -> outputs return to reset values immediately.
- start_i=1, ready_i=1, push pc 0x00,0x04,0x08 on consecutive cycles -> valid_o one cycle after each push; pc_o sequence 0x00,0x04,0x08 in order; count_o stays at most 1.
- ready_i=0, push pc 0x00..0x0C -> count_o=4, ready_o=0. Push 0x10 with valid_i=1 -> ignored. Release ready_i -> pops 0x00,0x04,0x08,0x0C in order, ready_o=1 after the first pop.
- Fill to 3 entries, then one cycle with push 0x20 + pop + flush_i=1 -> next cycle count_o=0, valid_o=0. No later output of 0x20 or the old entries.
- Wrap-around: 10 pushes with interleaved pops, pc 0x00..0x24 -> output order exactly 0x00..0x24, no loss or duplication across pointer wrap.
- FETCH_QUEUE_BYPASS_EN defined, queue empty, push pc 0x40 with ready_i=1 -> same cycle pc_o=0x40, valid_o=1; next cycle count_o=0. Undefined: valid_o=0 that cycle and pc_o=0x40 appears next cycle.
